// File: rtl/cpu_trace_pkg.sv
// Shared types for the retirement trace path: record kinds,
// the packed trace record and the drain state machine encoding.
package cpu_trace_pkg;

    localparam int TRACE_W = 16;

    typedef enum logic [1:0] {
        TRACE_REG  = 2'd0,
        TRACE_MEM  = 2'd1,
        TRACE_JMP  = 2'd2,
        TRACE_RSVD = 2'd3
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e          kind;
        logic [TRACE_W-1:0]   pc;
        logic [TRACE_W-1:0]   addr;
        logic [TRACE_W-1:0]   data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } trace_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Fall-through FIFO: the head entry is visible combinationally and
// a push into a full FIFO is accepted only when a pop frees a slot.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 50,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage is not reset; out_* are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Buffers one retirement record per cycle for the trace logger;
// on halt it stops capturing, drains the FIFO and flags done.
module retire_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         retire_valid,
    input  logic [1:0]   retire_kind,
    input  logic [W-1:0] retire_pc,
    input  logic [W-1:0] retire_addr,
    input  logic [W-1:0] retire_data,
    input  logic         halt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_kind,
    output logic [W-1:0] out_pc,
    output logic [W-1:0] out_addr,
    output logic [W-1:0] out_data,
    output logic         overflow,
    output logic [15:0]  drop_cnt,
    output logic         done
);

    localparam int RW = 2 + 3 * W;

    trace_state_e  r_state;
    logic          r_overflow;
    logic [15:0]   r_drop_cnt;
    logic          r_done;

    logic [RW-1:0] w_wdata;
    logic [RW-1:0] w_rdata;
    logic          w_full;
    logic          w_empty;
    logic [AW:0]   w_count;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_last_out;

    assign w_wdata    = {retire_kind, retire_pc, retire_addr, retire_data};
    assign w_push_req = (r_state == RUN) && retire_valid
                     && (retire_kind != TRACE_RSVD);
    assign out_valid  = !w_empty && (r_state != DONE);
    assign w_pop      = out_valid && out_ready;
    assign w_push     = w_push_req && (!w_full || w_pop);
    // A full FIFO without a pop refuses the record; old entries stay intact.
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_last_out = (w_count == '0)
                     || ((w_count == (AW+1)'(1)) && w_pop);

    assign {out_kind, out_pc, out_addr, out_data} = w_rdata;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
    assign done     = r_done;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RW),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (halt) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_last_out) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: capture, overflow, full
// push+pop, reserved kind, halt/drain/done and async reset.
module tb_retire_trace_buffer;

    logic        clk;
    logic        rst_n;
    logic        retire_valid;
    logic [1:0]  retire_kind;
    logic [15:0] retire_pc;
    logic [15:0] retire_addr;
    logic [15:0] retire_data;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [15:0] out_pc;
    logic [15:0] out_addr;
    logic [15:0] out_data;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        done;

    int checks;
    int failures;

    retire_trace_buffer #(
        .DEPTH (16),
        .W     (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .retire_valid (retire_valid),
        .retire_kind  (retire_kind),
        .retire_pc    (retire_pc),
        .retire_addr  (retire_addr),
        .retire_data  (retire_data),
        .halt         (halt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_kind     (out_kind),
        .out_pc       (out_pc),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic retire(input logic [1:0] k, input logic [15:0] pc,
                          input logic [15:0] a, input logic [15:0] d);
        retire_valid = 1'b1;
        retire_kind  = k;
        retire_pc    = pc;
        retire_addr  = a;
        retire_data  = d;
    endtask

    task automatic do_reset();
        retire_valid = 1'b0;
        halt         = 1'b0;
        out_ready    = 1'b0;
        rst_n        = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        retire_valid = 1'b0;
        retire_kind  = 2'd0;
        retire_pc    = '0;
        retire_addr  = '0;
        retire_data  = '0;
        halt         = 1'b0;
        out_ready    = 1'b0;
        rst_n        = 1'b1;

        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // single REG record, consumer always ready
        out_ready = 1'b1;
        retire(2'd0, 16'h0004, 16'h0003, 16'h00FF);
        tick();
        retire_valid = 1'b0;
        chk("reg_valid", 32'(out_valid), 32'd1);
        chk("reg_kind", 32'(out_kind), 32'd0);
        chk("reg_pc", 32'(out_pc), 32'h0004);
        chk("reg_addr", 32'(out_addr), 32'h0003);
        chk("reg_data", 32'(out_data), 32'h00FF);
        tick();
        chk("reg_empty", 32'(out_valid), 32'd0);

        // 18 MEM records into a stalled 16-deep FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            retire(2'd1, 16'h0010 + 16'(i), 16'h1000 + 16'(i), 16'(i));
            tick();
        end
        retire_valid = 1'b0;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_head", 32'(out_pc), 32'h0010);

        // full: JMP push together with a pop
        retire(2'd2, 16'h0030, 16'h0000, 16'h0100);
        out_ready = 1'b1;
        tick();
        retire_valid = 1'b0;
        chk("fullpp_drop", 32'(drop_cnt), 32'd2);
        for (int i = 1; i < 16; i++) begin
            chk("drain_pc", 32'(out_pc), 32'h0010 + 32'(i));
            chk("drain_kind", 32'(out_kind), 32'd1);
            tick();
        end
        chk("jmp_valid", 32'(out_valid), 32'd1);
        chk("jmp_kind", 32'(out_kind), 32'd2);
        chk("jmp_pc", 32'(out_pc), 32'h0030);
        chk("jmp_data", 32'(out_data), 32'h0100);
        tick();
        chk("jmp_last", 32'(out_valid), 32'd0);
        chk("ovf_hold", 32'(overflow), 32'd1);

        // reserved kind is neither stored nor dropped
        do_reset();
        for (int i = 0; i < 5; i++) begin
            retire(2'd3, 16'h0200 + 16'(i), 16'h0, 16'h0);
            tick();
            chk("rsvd_valid", 32'(out_valid), 32'd0);
        end
        retire_valid = 1'b0;
        chk("rsvd_drop", 32'(drop_cnt), 32'd0);
        chk("rsvd_ovf", 32'(overflow), 32'd0);

        // halt with the halting instruction captured
        for (int i = 0; i < 3; i++) begin
            retire(2'd0, 16'h0040 + 16'(i), 16'(i), 16'h0A00 + 16'(i));
            tick();
        end
        retire(2'd0, 16'h0043, 16'h0003, 16'h0A03);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        retire(2'd0, 16'h0050, 16'h0005, 16'h0B00);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_done", 32'(done), 32'd0);
            chk("stall_head", 32'(out_pc), 32'h0040);
        end
        retire_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("halt_valid", 32'(out_valid), 32'd1);
            chk("halt_pc", 32'(out_pc), 32'h0040 + 32'(i));
            chk("halt_done", 32'(done), 32'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("done_hi", 32'(done), 32'd1);
            chk("done_valid", 32'(out_valid), 32'd0);
            tick();
        end

        // asynchronous reset mid-drain
        do_reset();
        for (int i = 0; i < 17; i++) begin
            retire(2'd1, 16'h0060 + 16'(i), 16'h0, 16'(i));
            tick();
        end
        retire_valid = 1'b0;
        chk("pre_drop", 32'(drop_cnt), 32'd1);
        halt = 1'b1;
        out_ready = 1'b1;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        out_ready = 1'b0;
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_pc", 32'(out_pc), 32'h006B);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        retire(2'd2, 16'h0077, 16'h0000, 16'h0123);
        tick();
        retire_valid = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd1);
        chk("post_kind", 32'(out_kind), 32'd2);
        chk("post_pc", 32'(out_pc), 32'h0077);
        chk("post_data", 32'(out_data), 32'h0123);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
